// File: rtl/instr_encoder_if.sv
// Loader-side field handshake and program-RAM write port of the
// Overture instruction encoder, bundled as one interface.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_class;
  logic [5:0]        in_arg_a;
  logic [2:0]        in_arg_b;
  logic              restart;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport slave (
    input  in_valid,
    input  in_class,
    input  in_arg_a,
    input  in_arg_b,
    input  restart,
    input  mem_ready,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_data,
    output count,
    output full,
    output err
  );

  modport master (
    output in_valid,
    output in_class,
    output in_arg_a,
    output in_arg_b,
    output restart,
    output mem_ready,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_data,
    input  count,
    input  full,
    input  err
  );
endinterface

// File: rtl/instr_encoder.sv
// Overture opcode encoder and sequential program-memory writer.
// Define ENC_CHECK_EN to reject illegal fields and raise the sticky err.
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);

  localparam logic [1:0] CLS_IMM  = 2'd0;
  localparam logic [1:0] CLS_CALC = 2'd1;
  localparam logic [1:0] CLS_COPY = 2'd2;
  localparam logic [1:0] CLS_COND = 2'd3;

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_MAX = '1;
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

`ifdef ENC_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              we_q;
  logic [ADDR_W:0]   cnt_q;
  logic              full_q;
  logic              err_q;
  logic              pend_q;

  logic [7:0]        opcode_d;
  logic              bad_d;
  logic [ADDR_W-1:0] ptr_d;
  logic [ADDR_W:0]   cnt_d;
  logic              rewind_d;

  function automatic logic [7:0] encode(
    input logic [1:0] cls,
    input logic [5:0] a,
    input logic [2:0] b
  );
    logic [7:0] op;
    op = 8'h00;
    unique case (1'b1)
      cls == CLS_IMM:  op = {2'b00, a};
      cls == CLS_CALC: op = {2'b01, 3'b000, a[2:0]};
      cls == CLS_COPY: op = {2'b10, a[2:0], b};
      cls == CLS_COND: op = {2'b11, 3'b000, a[2:0]};
    endcase
    return op;
  endfunction

  function automatic logic illegal(
    input logic [1:0] cls,
    input logic [5:0] a,
    input logic [2:0] b
  );
    logic bad;
    bad = 1'b0;
    if (cls != CLS_IMM && a[5:3] != 3'd0)
      bad = 1'b1;
    if (cls == CLS_CALC && a[2:0] > 3'd5)
      bad = 1'b1;
    if (cls == CLS_COPY && (a[2:0] == 3'd7 || b == 3'd7))
      bad = 1'b1;
    return bad;
  endfunction

  assign opcode_d = encode(bus.in_class, bus.in_arg_a, bus.in_arg_b);
  assign bad_d    = CHECK && illegal(bus.in_class, bus.in_arg_a,
                                     bus.in_arg_b);
  assign ptr_d    = ptr_q + PTR_ONE;
  assign cnt_d    = cnt_q + CNT_ONE;
  // A restart seen at any point of a write rewinds once that write lands.
  assign rewind_d = pend_q | bus.restart;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= BASE;
      addr_q  <= BASE;
      data_q  <= 8'h00;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.restart) begin
            ptr_q  <= BASE;
            cnt_q  <= '0;
            full_q <= 1'b0;
            err_q  <= 1'b0;
          end else if (bus.in_valid) begin
            if (bad_d) begin
              err_q <= 1'b1;
            end else begin
              addr_q  <= ptr_q;
              data_q  <= opcode_d;
              we_q    <= 1'b1;
              state_q <= WRITE;
            end
          end
        end
        WRITE: begin
          if (bus.restart) begin
            pend_q <= 1'b1;
            err_q  <= 1'b0;
          end
          if (bus.mem_ready) begin
            we_q <= 1'b0;
            if (rewind_d) begin
              ptr_q   <= BASE;
              cnt_q   <= '0;
              pend_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              ptr_q <= ptr_d;
              cnt_q <= cnt_d;
              if (ptr_q == PTR_MAX) begin
                full_q  <= 1'b1;
                state_q <= FULL;
              end else begin
                state_q <= IDLE;
              end
            end
          end
        end
        FULL: begin
          if (bus.restart) begin
            ptr_q   <= BASE;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready = !rst && (state_q == IDLE);
  assign bus.mem_we   = we_q;
  assign bus.mem_addr = addr_q;
  assign bus.mem_data = data_q;
  assign bus.count    = cnt_q;
  assign bus.full     = full_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: an 8-bit-address instance for the
// encoding/flow cases and a 2-bit-address instance for the full case.
module tb_instr_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(8)) busa ();
  instr_encoder_if #(.ADDR_W(2)) busb ();

  instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (busa.slave)
  );

  instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (busb.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive_a(input logic [1:0] c, input logic [5:0] a,
                         input logic [2:0] b);
    busa.in_valid = 1'b1;
    busa.in_class = c;
    busa.in_arg_a = a;
    busa.in_arg_b = b;
  endtask

  // Full handshake on dut_a with mem_ready already high.
  task automatic wr_a(input logic [1:0] c, input logic [5:0] a,
                      input logic [2:0] b, input logic [7:0] ed,
                      input logic [7:0] ea, input logic [8:0] ec);
    drive_a(c, a, b);
    step();
    busa.in_valid = 1'b0;
    chk("wr_we", 32'(busa.mem_we), 32'd1);
    chk("wr_addr", 32'(busa.mem_addr), 32'(ea));
    chk("wr_data", 32'(busa.mem_data), 32'(ed));
    chk("wr_busy", 32'(busa.in_ready), 32'd0);
    step();
    chk("wr_done", 32'(busa.mem_we), 32'd0);
    chk("wr_count", 32'(busa.count), 32'(ec));
    chk("wr_ready", 32'(busa.in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    busa.in_valid = 1'b0; busa.in_class = 2'd0;
    busa.in_arg_a = 6'd0; busa.in_arg_b = 3'd0;
    busa.restart = 1'b0;  busa.mem_ready = 1'b1;
    busb.in_valid = 1'b0; busb.in_class = 2'd0;
    busb.in_arg_a = 6'd0; busb.in_arg_b = 3'd0;
    busb.restart = 1'b0;  busb.mem_ready = 1'b1;

    step();
    step();
    chk("rst_in_ready", 32'(busa.in_ready), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_we", 32'(busa.mem_we), 32'd0);
    chk("rst_addr", 32'(busa.mem_addr), 32'd0);
    chk("rst_data", 32'(busa.mem_data), 32'd0);
    chk("rst_count", 32'(busa.count), 32'd0);
    chk("rst_full", 32'(busa.full), 32'd0);
    chk("rst_err", 32'(busa.err), 32'd0);
    chk("rst_ready", 32'(busa.in_ready), 32'd1);

    wr_a(2'd0, 6'h2A, 3'd0, 8'h2A, 8'd0, 9'd1);
    wr_a(2'd1, 6'd4,  3'd0, 8'h44, 8'd1, 9'd2);
    wr_a(2'd2, 6'd3,  3'd6, 8'h9E, 8'd2, 9'd3);
    wr_a(2'd3, 6'd7,  3'd0, 8'hC7, 8'd3, 9'd4);

    busa.mem_ready = 1'b0;
    drive_a(2'd0, 6'h15, 3'd0);
    step();
    busa.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_we", 32'(busa.mem_we), 32'd1);
      chk("bp_addr", 32'(busa.mem_addr), 32'd4);
      chk("bp_data", 32'(busa.mem_data), 32'h15);
      chk("bp_ready", 32'(busa.in_ready), 32'd0);
      step();
    end
    busa.mem_ready = 1'b1;
    step();
    chk("bp_done", 32'(busa.mem_we), 32'd0);
    chk("bp_count", 32'(busa.count), 32'd5);

    busa.mem_ready = 1'b0;
    drive_a(2'd3, 6'd2, 3'd0);
    step();
    busa.in_valid = 1'b0;
    chk("rw_addr", 32'(busa.mem_addr), 32'd5);
    chk("rw_data", 32'(busa.mem_data), 32'hC2);
    busa.restart = 1'b1;
    step();
    busa.restart = 1'b0;
    chk("rw_hold_we", 32'(busa.mem_we), 32'd1);
    chk("rw_hold_count", 32'(busa.count), 32'd5);
    step();
    step();
    chk("rw_still_addr", 32'(busa.mem_addr), 32'd5);
    chk("rw_still_we", 32'(busa.mem_we), 32'd1);
    busa.mem_ready = 1'b1;
    step();
    chk("rw_done", 32'(busa.mem_we), 32'd0);
    chk("rw_count", 32'(busa.count), 32'd0);
    chk("rw_ready", 32'(busa.in_ready), 32'd1);
    wr_a(2'd0, 6'd1, 3'd0, 8'h01, 8'd0, 9'd1);

    drive_a(2'd1, 6'd6, 3'd0);
    step();
    busa.in_valid = 1'b0;
`ifdef ENC_CHECK_EN
    chk("ill_we", 32'(busa.mem_we), 32'd0);
    chk("ill_err", 32'(busa.err), 32'd1);
    chk("ill_count", 32'(busa.count), 32'd1);
    chk("ill_ready", 32'(busa.in_ready), 32'd1);
`else
    chk("ill_we", 32'(busa.mem_we), 32'd1);
    chk("ill_data", 32'(busa.mem_data), 32'h46);
    chk("ill_addr", 32'(busa.mem_addr), 32'd1);
    step();
    chk("ill_count", 32'(busa.count), 32'd2);
    chk("ill_err", 32'(busa.err), 32'd0);
`endif

    drive_a(2'd0, 6'd5, 3'd0);
    busa.restart = 1'b1;
    step();
    busa.in_valid = 1'b0;
    busa.restart = 1'b0;
    chk("rsv_we", 32'(busa.mem_we), 32'd0);
    chk("rsv_count", 32'(busa.count), 32'd0);
    chk("rsv_err", 32'(busa.err), 32'd0);
    chk("rsv_ready", 32'(busa.in_ready), 32'd1);

    busa.mem_ready = 1'b0;
    drive_a(2'd0, 6'h3F, 3'd0);
    step();
    busa.in_valid = 1'b0;
    chk("rwr_we", 32'(busa.mem_we), 32'd1);
    rst = 1'b1;
    step();
    chk("rwr_we0", 32'(busa.mem_we), 32'd0);
    chk("rwr_addr0", 32'(busa.mem_addr), 32'd0);
    chk("rwr_data0", 32'(busa.mem_data), 32'd0);
    chk("rwr_count0", 32'(busa.count), 32'd0);
    chk("rwr_full0", 32'(busa.full), 32'd0);
    chk("rwr_ready0", 32'(busa.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rwr_ready1", 32'(busa.in_ready), 32'd1);
    busa.mem_ready = 1'b1;

    step();
    for (int i = 0; i < 4; i++) begin
      busb.in_valid = 1'b1;
      busb.in_arg_a = 6'(i + 16);
      step();
      busb.in_valid = 1'b0;
      chk("fb_addr", 32'(busb.mem_addr), 32'(i));
      chk("fb_data", 32'(busb.mem_data), 32'(i + 16));
      step();
    end
    chk("fb_full", 32'(busb.full), 32'd1);
    chk("fb_count", 32'(busb.count), 32'd4);
    chk("fb_ready", 32'(busb.in_ready), 32'd0);
    busb.in_valid = 1'b1;
    busb.in_arg_a = 6'h2C;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fb_nowe", 32'(busb.mem_we), 32'd0);
      chk("fb_count_hold", 32'(busb.count), 32'd4);
    end
    busb.in_valid = 1'b0;
    busb.restart = 1'b1;
    step();
    busb.restart = 1'b0;
    chk("fb_rs_full", 32'(busb.full), 32'd0);
    chk("fb_rs_count", 32'(busb.count), 32'd0);
    chk("fb_rs_ready", 32'(busb.in_ready), 32'd1);
    busb.in_valid = 1'b1;
    busb.in_arg_a = 6'h09;
    step();
    busb.in_valid = 1'b0;
    chk("fb_rs_addr", 32'(busb.mem_addr), 32'd0);
    chk("fb_rs_data", 32'(busb.mem_data), 32'h09);
    chk("fb_rs_we", 32'(busb.mem_we), 32'd1);
    step();
    chk("fb_rs_cnt1", 32'(busb.count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
